// File: rtl/inst_fetch_queue_pkg.sv
// inst_fetch_queue_pkg: shared types and defaults for the instruction fetch queue.
package inst_fetch_queue_pkg;
    localparam int FQ_DEPTH = 8;
    localparam logic [31:0] FQ_RESET_PC = 32'h0000_0000;
    typedef logic [31:0] inst_t;
    typedef logic [31:0] addr_t;
    function automatic addr_t word_align(input addr_t a);
        return {a[31:2], 2'b00};
    endfunction
endpackage

// File: rtl/inst_fetch_queue_if.sv
// inst_fetch_queue_if: instruction RAM port, redirect and dual-issue decode signals.
interface inst_fetch_queue_if import inst_fetch_queue_pkg::*; #(
    parameter int DEPTH = FQ_DEPTH
);
    addr_t iaddr;
    logic ice;
    inst_t inst;
    logic redirect;
    addr_t redirect_pc;
    logic [1:0] deq_cnt;
    logic out0_valid;
    logic out1_valid;
    inst_t out0_inst;
    inst_t out1_inst;
    addr_t out0_pc;
    addr_t out1_pc;
    logic [$clog2(DEPTH):0] count;
    modport master (
        output iaddr, ice, out0_valid, out1_valid, out0_inst, out1_inst, out0_pc, out1_pc, count,
        input inst, redirect, redirect_pc, deq_cnt
    );
    modport slave (
        input iaddr, ice, out0_valid, out1_valid, out0_inst, out1_inst, out0_pc, out1_pc, count,
        output inst, redirect, redirect_pc, deq_cnt
    );
endinterface

// File: rtl/inst_fetch_queue_fq_storage.sv
// fq_storage: circular PC+instruction buffer, one write port, reads at head and head+1.
module fq_storage import inst_fetch_queue_pkg::*; #(
    parameter int DEPTH = FQ_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_flush,
    input  logic          i_push,
    input  addr_t         i_pc,
    input  inst_t         i_inst,
    input  logic [1:0]    i_pop,
    output addr_t         o_pc0,
    output addr_t         o_pc1,
    output inst_t         o_inst0,
    output inst_t         o_inst1,
    output logic [CW-1:0] o_count
);
    logic [AW-1:0] r_head, r_tail, w_head1;
    logic [CW-1:0] r_count;
    logic [1:0] w_pop;
    addr_t r_pc [DEPTH];
    inst_t r_inst [DEPTH];
    always_comb begin
        // over-requested pops are clamped to what is actually held
        w_pop = (CW'(i_pop) > r_count) ? r_count[1:0] : i_pop;
        w_head1 = r_head + AW'(1);
        o_pc0 = r_pc[r_head];
        o_pc1 = r_pc[w_head1];
        o_inst0 = r_inst[r_head];
        o_inst1 = r_inst[w_head1];
        o_count = r_count;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || i_flush) begin
            r_head <= '0;
            r_tail <= '0;
            r_count <= '0;
        end else begin
            r_head <= r_head + AW'(w_pop);
            r_tail <= r_tail + AW'(i_push);
            r_count <= r_count + CW'(i_push) - CW'(w_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_pc[r_tail] <= i_pc;
            r_inst[r_tail] <= i_inst;
        end
    end
endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: sequential fetch PC, single outstanding RAM read, redirect flush,
// feeding a circular queue that presents two in-order instructions to decode.
module inst_fetch_queue import inst_fetch_queue_pkg::*; #(
    parameter int DEPTH = FQ_DEPTH,
    parameter logic [31:0] RESET_PC = FQ_RESET_PC
) (
    input logic cpu_clk,
    input logic resetn,
    inst_fetch_queue_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    addr_t r_fetch_pc, r_inflight_pc;
    logic r_inflight, r_kill;
    logic w_ice, w_push;
    addr_t w_pc0, w_pc1;
    inst_t w_inst0, w_inst1;
    logic [CW-1:0] w_count;
    always_comb begin
        // credit counts the outstanding read but not this cycle's pops
        w_ice = resetn && !bus.redirect && (int'(w_count) + int'(r_inflight) < DEPTH);
        w_push = r_inflight && !r_kill;
        bus.iaddr = r_fetch_pc;
        bus.ice = w_ice;
        bus.out0_valid = w_count != '0;
        bus.out1_valid = w_count >= CW'(2);
        bus.out0_pc = w_pc0;
        bus.out1_pc = w_pc1;
        bus.out0_inst = w_inst0;
        bus.out1_inst = w_inst1;
        bus.count = w_count;
    end
    always_ff @(posedge cpu_clk or negedge resetn) begin
        if (!resetn) begin
            r_fetch_pc <= RESET_PC;
            r_inflight_pc <= RESET_PC;
            r_inflight <= 1'b0;
            r_kill <= 1'b0;
        end else begin
            r_inflight <= w_ice;
            r_kill <= bus.redirect;
            if (bus.redirect) begin
                r_fetch_pc <= word_align(bus.redirect_pc);
            end else if (w_ice) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
                r_inflight_pc <= r_fetch_pc;
            end
        end
    end
    fq_storage #(.DEPTH(DEPTH)) u_storage (
        .clk     (cpu_clk),
        .rst_n   (resetn),
        .i_flush (bus.redirect),
        .i_push  (w_push),
        .i_pc    (r_inflight_pc),
        .i_inst  (bus.inst),
        .i_pop   (bus.deq_cnt),
        .o_pc0   (w_pc0),
        .o_pc1   (w_pc1),
        .o_inst0 (w_inst0),
        .o_inst1 (w_inst1),
        .o_count (w_count)
    );
endmodule
